lsu_mem_stage: RTL
==================

// Module: lsu_mem_stage
// PURPOSE
//  Parametrised load/store unit for the MEM pipeline stage. Issues one dmem request per load/store.
//  Holds the pipeline with `stall` until dmem responds, then presents registered, lane-aligned,
//  sign/zero-extended load data for one cycle. Supports flush of an in-flight access; the
//  outstanding response is drained and discarded.
// PARAMETERS
//  DATA_W  32  dmem data width / XLEN; 32 or 64 only; BYTES=DATA_W/8, OFS_W=$clog2(BYTES)
//  ADDR_W  32  byte-address width
// PORTS
//  clk         in   1          clock, all state on posedge
//  rst         in   1          synchronous, active-high reset
//  in_valid    in   1          MEM-stage instruction valid
//  in_load     in   1          instruction is a load
//  in_store    in   1          instruction is a store (never together with in_load)
//  in_funct3   in   3          RV funct3: size/sign
//  in_addr     in   ADDR_W     effective byte address (rs1+imm)
//  in_wdata    in   DATA_W     store data, LSB-justified
//  flush       in   1          kill the current MEM instruction
//  dmem_addr   out  ADDR_W     word-aligned address (low OFS_W bits 0)
//  dmem_rmask  out  BYTES      read byte-enable; non-zero only in issue cycle
//  dmem_wmask  out  BYTES      write byte-enable; non-zero only in issue cycle
//  dmem_wdata  out  DATA_W     store data shifted to byte lanes
//  dmem_rdata  in   DATA_W     read data, valid with dmem_resp
//  dmem_resp   in   1          one-cycle response pulse
//  stall       out  1          hold all upstream pipeline registers
//  done        out  1          access complete this cycle (1-cycle pulse)
//  ld_data     out  DATA_W     extended load result, valid while done && load
//  trap        out  1          misaligned-access trap (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE; stall/done/trap=0; ld_data=0; dmem masks=0; dmem_addr/wdata=0. Pending response discarded.
//  States: IDLE, WAIT, DONE, DRAIN.
//  IDLE:
//   - in_valid & (in_load|in_store) & !flush: drive request this cycle, stall=1, go WAIT.
//   - Non-memory or invalid instruction: stall=0, no request.
//   - Stray dmem_resp ignored.
//  WAIT: masks=0, stall=1.
//   - dmem_resp & !flush: register extended data into ld_data, go DONE.
//   - flush & !dmem_resp: go DRAIN.
//   - flush & dmem_resp same cycle: go IDLE, data dropped, done stays 0.
//  DONE: stall=0, done=1, go IDLE. No new issue in DONE: the completing instruction is still on in_*.
//  DRAIN: stall=1, masks=0; on dmem_resp go IDLE. done never asserted.
//  Latency: issue at T, resp at T+k (k>=1) -> done at T+k+1. Minimum 2 stall cycles per access.
//  Size from funct3[1:0]: 00=B, 01=H, 10=W, 11=D.
//   - D is legal only when DATA_W=64; otherwise rmask=wmask=0, done with ld_data=0.
//   - funct3[2]=1 selects zero-extend. lwu is 110.
//  ofs = in_addr[OFS_W-1:0]. mask = ((1<<size_bytes)-1) << ofs. wdata = in_wdata << (8*ofs).
//  Load extract: ld_data = ext(dmem_rdata >> 8*ofs_q, size_q, unsigned_q), using values captured at issue.
//  Issue-time funct3/offset are registered; later in_* changes have no effect.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined:
//   - access with ofs not a multiple of size: no dmem request, go DONE next cycle with trap=1, ld_data=0.
//   - trap clears with done.
//  MISALIGN_TRAP_EN undefined:
//   - trap tied 0; ofs low bits below size are forced to 0 (lh @ ofs 1 -> ofs 0); access proceeds normally.
// TESTING
//  1 DATA_W=32: lb addr 0x103, rdata 0x80AA_BBCC, resp after 3 cycles -> rmask 4'b1000; ld_data 0xFFFF_FF80; 4 stall cycles.
//  2 sh addr 0x202, wdata 0x0000_1234 -> wmask 4'b1100, dmem_wdata 0x1234_xxxx lanes [31:16]; done 1 cycle after resp.
//  3 DATA_W=64: ld addr 0x08 -> rmask 8'hFF, ld_data == rdata. lwu addr 0x0C, rdata[63:32]=0x8000_0001 -> ld_data 0x0000_0000_8000_0001.
//  4 flush in WAIT, resp 2 cycles later -> DRAIN, stall held until resp, done never 1, next load issues cleanly.
//  5 rst asserted in WAIT, resp arrives after rst drops -> ignored; all outputs 0; no done.
//  6 lw addr 0x102: trap=1, no request, done next cycle (MISALIGN_TRAP_EN). Otherwise rmask 4'b1111 @0x100, trap=0.

Source files
------------

// File: rtl/lsu_mem_if.sv
// Bundle of MEM-stage instruction, flush, data-memory and result signals for lsu_mem_stage.
// The slave modport is the LSU's view; the master modport is the pipeline/memory side.
interface lsu_mem_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    localparam int BYTES = DATA_W / 8;

    // Request/response protocol: a request exists only in the cycle where a mask is non-zero and
    // is accepted unconditionally by memory; memory answers with exactly one dmem_resp pulse
    // carrying dmem_rdata, at least one cycle later. The pipeline holds in_* while stall is high.
    logic              in_valid;
    logic              in_load;
    logic              in_store;
    logic [2:0]        in_funct3;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_wdata;
    logic              flush;

    logic [ADDR_W-1:0] dmem_addr;
    logic [BYTES-1:0]  dmem_rmask;
    logic [BYTES-1:0]  dmem_wmask;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_resp;

    logic              stall;
    logic              done;
    logic [DATA_W-1:0] ld_data;
    logic              trap;

    modport slave (
        input  in_valid, in_load, in_store, in_funct3, in_addr, in_wdata, flush,
        input  dmem_rdata, dmem_resp,
        output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
        output stall, done, ld_data, trap
    );

    modport master (
        output in_valid, in_load, in_store, in_funct3, in_addr, in_wdata, flush,
        output dmem_rdata, dmem_resp,
        input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
        input  stall, done, ld_data, trap
    );
endinterface

// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: one dmem request per access, stalls until the response, then a
// one-cycle done with extended load data. Optional misaligned trap via `MISALIGN_TRAP_EN.
module lsu_mem_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    lsu_mem_if.slave   bus,
    output logic [1:0] dbg_state
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFS_W = $clog2(BYTES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [OFS_W-1:0]  ofs_q, ofs_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic              load_q, load_d;
    logic [DATA_W-1:0] ld_data_q, ld_data_d;
    logic              trap_q, trap_d;

    // Issue-side decode
    logic              issue;
    logic [1:0]        size;
    logic              size_ok;
    logic [OFS_W-1:0]  ofs_raw;
    logic [OFS_W-1:0]  low_bits;
    logic [OFS_W-1:0]  ofs_eff;
    logic              mis_trap;
    logic              bad;
    logic [15:0]       base_mask;
    logic [BYTES-1:0]  lane_mask;
    logic [DATA_W-1:0] wdata_sh;

    always_comb begin
        issue    = bus.in_valid & (bus.in_load | bus.in_store) & ~bus.flush;
        size     = bus.in_funct3[1:0];
        size_ok  = (size != 2'b11) || (DATA_W == 64);
        ofs_raw  = bus.in_addr[OFS_W-1:0];
        low_bits = OFS_W'((4'd1 << size) - 4'd1);
`ifdef MISALIGN_TRAP_EN
        mis_trap = size_ok & (|(ofs_raw & low_bits));
        ofs_eff  = ofs_raw;
`else
        // Misaligned offsets are rounded down to the access size instead of trapping.
        mis_trap = 1'b0;
        ofs_eff  = ofs_raw & ~low_bits;
`endif
        bad = mis_trap | ~size_ok;
        case (size)
            2'b00:   base_mask = 16'h0001;
            2'b01:   base_mask = 16'h0003;
            2'b10:   base_mask = 16'h000F;
            default: base_mask = 16'h00FF;
        endcase
        lane_mask = BYTES'(base_mask << ofs_eff);
        wdata_sh  = bus.in_wdata << {ofs_eff, 3'b000};
    end

    // Load extraction uses only the offset/size/sign captured at issue.
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] keep;
    logic              msb;
    logic [DATA_W-1:0] ext;

    always_comb begin
        shifted = bus.dmem_rdata >> {ofs_q, 3'b000};
        case (size_q)
            2'b00: begin
                keep = DATA_W'(8'hFF);
                msb  = shifted[7];
            end
            2'b01: begin
                keep = DATA_W'(16'hFFFF);
                msb  = shifted[15];
            end
            2'b10: begin
                keep = DATA_W'(32'hFFFF_FFFF);
                msb  = shifted[31];
            end
            default: begin
                keep = '1;
                msb  = shifted[DATA_W-1];
            end
        endcase
        ext = (shifted & keep) | ({DATA_W{msb & ~uns_q}} & ~keep);
    end

    // Request outputs are combinational so the access leaves in the issue cycle itself.
    logic [ADDR_W-1:0] req_addr;
    logic [BYTES-1:0]  req_rmask;
    logic [BYTES-1:0]  req_wmask;
    logic [DATA_W-1:0] req_wdata;
    logic              stall_c;

    always_comb begin
        state_d   = state_q;
        ofs_d     = ofs_q;
        size_d    = size_q;
        uns_d     = uns_q;
        load_d    = load_q;
        ld_data_d = ld_data_q;
        trap_d    = trap_q;
        req_addr  = '0;
        req_rmask = '0;
        req_wmask = '0;
        req_wdata = '0;
        stall_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (issue) begin
                    stall_c = 1'b1;
                    ofs_d   = ofs_eff;
                    size_d  = size;
                    uns_d   = bus.in_funct3[2];
                    load_d  = bus.in_load;
                    if (bad) begin
                        // Illegal size or trapping offset: no memory traffic, complete next cycle.
                        state_d   = DONE;
                        ld_data_d = '0;
                        trap_d    = mis_trap;
                    end else begin
                        state_d   = WAIT;
                        req_addr  = {bus.in_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
                        req_wdata = wdata_sh;
                        if (bus.in_load) req_rmask = lane_mask;
                        else             req_wmask = lane_mask;
                    end
                end
            end
            WAIT: begin
                stall_c = 1'b1;
                if (bus.dmem_resp && !bus.flush) begin
                    state_d   = DONE;
                    ld_data_d = load_q ? ext : '0;
                    trap_d    = 1'b0;
                end else if (bus.dmem_resp && bus.flush) begin
                    state_d = IDLE;
                end else if (bus.flush) begin
                    state_d = DRAIN;
                end
            end
            DONE: begin
                // The completing instruction is still on in_*, so nothing may issue here.
                state_d   = IDLE;
                ld_data_d = '0;
                trap_d    = 1'b0;
            end
            DRAIN: begin
                stall_c = 1'b1;
                if (bus.dmem_resp) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ofs_q     <= '0;
            size_q    <= '0;
            uns_q     <= 1'b0;
            load_q    <= 1'b0;
            ld_data_q <= '0;
            trap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ofs_q     <= ofs_d;
            size_q    <= size_d;
            uns_q     <= uns_d;
            load_q    <= load_d;
            ld_data_q <= ld_data_d;
            trap_q    <= trap_d;
        end
    end

    assign bus.dmem_addr  = req_addr;
    assign bus.dmem_rmask = req_rmask;
    assign bus.dmem_wmask = req_wmask;
    assign bus.dmem_wdata = req_wdata;
    assign bus.stall      = stall_c;
    assign bus.done       = (state_q == DONE);
    assign bus.ld_data    = ld_data_q;
    assign bus.trap       = trap_q;
    assign dbg_state      = state_q;
endmodule
